pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. Each cycle it decides whether the F/D pipeline register holds, takes a bubble (NOP `0x00000013`, pc 0) or advances. It makes the same decision for the D/E register. It sequences multi-cycle execute operations (mul/div) through a start/done handshake and detects load-use hazards. It also gives taken branches/jumps priority as redirects. Its outputs drive the `stall`/`jb` inputs of the fetch-decode register and the equivalent controls of the PC and E-stage registers.

## Interface
- `MC_TIMEOUT`, 64: max cycles waited for `mc_done` before abort; legal range 2..255.
- `CNT_W`, 32: width of performance counters.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-low. Asserts immediately; deasserts synchronously to `clk`.
- `D_rs1`, `D_rs2`  in  5 each  source registers of the instruction in D.
- `D_rs1_used`, `D_rs2_used`  in  1 each  the corresponding source is actually read.
- `E_rd`  in  5  destination register of the instruction in E.
- `E_is_load`  in  1  the instruction in E is a load.
- `E_is_mc`  in  1  the instruction in E is a multi-cycle op.
- `jb`  in  1  branch taken or jump, resolved in E.
- `imem_ready`  in  1  fetch data valid this cycle.
- `mc_done`  in  1  one-cycle pulse from the multi-cycle unit: result valid.
- `stall_F`  out  1  hold PC.
- `stall_D`  out  1  hold the F/D register.
- `flush_D`  out  1  load NOP into the F/D register; drives its `jb`.
- `stall_E`  out  1  hold the D/E register.
- `flush_E`  out  1  load bubble into the D/E register.
- `mc_go`  out  1  one-cycle start pulse to the multi-cycle unit.
- `mc_err`  out  1  sticky: a multi-cycle op timed out.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters; see Configuration.

## Operation
- FSM states: RUN (2'b00), MC_WAIT (2'b01), MC_DRAIN (2'b10).
- Load-use hazard, LU:
  - `E_is_load && E_rd!=0`, and
  - `(D_rs1_used && D_rs1==E_rd) || (D_rs2_used && D_rs2==E_rd)`.
- RUN, first matching rule wins:
  1. `E_is_mc`: `mc_go=1`, `stall_F=stall_D=stall_E=1`; next state MC_WAIT; timer loaded with 0.
  2. `jb`: `flush_D=1`, `flush_E=1`; no stalls. A simultaneous LU is ignored because D is squashed.
  3. LU: `stall_F=stall_D=1`, `flush_E=1`. This lasts exactly one cycle, because the load then leaves E.
  4. `!imem_ready`: `stall_F=1`, `flush_D=1`.
  5. Otherwise all outputs 0.
- MC_WAIT:
  - `stall_F=stall_D=stall_E=1`. `jb`, LU and `imem_ready` are ignored.
  - Timer increments every cycle.
  - On `mc_done`: next state MC_DRAIN.
  - On timer reaching `MC_TIMEOUT-1` without `mc_done`: set `mc_err`; next state MC_DRAIN.
- MC_DRAIN:
  - One cycle with all stalls 0, so E writes the result and advances.
  - The RUN rules 2–4 apply. Rule 1 is suppressed in this cycle, so the same op never restarts.
  - Next state RUN.
- A `mc_done` pulse in RUN or MC_DRAIN is ignored.
- `mc_err` is cleared only by reset.
- Outputs are combinational from the state and the inputs. While `rst` is low, every output is forced to 0.

## Timing
- Reset values:
  - state RUN, timer 0, `mc_err` 0, counters 0.
  - All stall/flush outputs and `mc_go` are 0.
- Load-use costs 1 bubble. Taken `jb` costs 2 bubbles: the F/D register gets a NOP on the next edge, and the D/E register gets a bubble on the same edge.
- Multi-cycle op, with `mc_go` asserted in cycle t and `mc_done` in cycle t+k:
  - stalls are high in cycles t..t+k;
  - MC_DRAIN is cycle t+k+1;
  - total penalty is k+1 cycles.
- Timeout: with `mc_go` in cycle t, `mc_err` rises at the edge ending cycle t+MC_TIMEOUT.
- Reset asserted mid-MC_WAIT: state returns to RUN asynchronously; no `mc_go` is reissued until `E_is_mc` is seen in RUN after reset.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `stall_F=1`.
  - `flush_cnt` increments on every cycle with `flush_D|flush_E`.
  - Both counters saturate at all-ones.
- Undefined: no counter registers are built; `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset, then `imem_ready=1` and no hazards for 10 cycles:
  - all stall/flush outputs 0, state RUN;
  - with PERF, both counters still 0.
- Load-use: E has `E_is_load=1`, `E_rd=5`; D has `D_rs2=5`, `D_rs2_used=1`:
  - that cycle `stall_F=stall_D=flush_E=1`;
  - next cycle (E now bubble) all outputs 0.
- Same as above plus `jb=1`: `flush_D=flush_E=1`, `stall_F=0`. Also `E_rd=0` with a matching source: no stall.
- `E_is_mc=1`, `mc_done` 4 cycles after `mc_go`:
  - `mc_go` high for 1 cycle;
  - stalls high for 5 cycles, then MC_DRAIN for 1 cycle with stalls 0;
  - no second `mc_go`.
- `MC_TIMEOUT=8`, `mc_done` never arrives:
  - `mc_err` rises 8 cycles after `mc_go`, then MC_DRAIN, then RUN.
  - Assert `rst` low: `mc_err` clears immediately.
- PERF build: 3 `imem_ready=0` cycles plus 1 `jb` give `stall_cnt=3`, `flush_cnt=4`.
- Non-PERF build: both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, redirect, fetch-wait and mul/div sequencing.
// Optional saturating stall/flush performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       D_rs1,
   input  logic [4:0]       D_rs2,
   input  logic             D_rs1_used,
   input  logic             D_rs2_used,
   input  logic [4:0]       E_rd,
   input  logic             E_is_load,
   input  logic             E_is_mc,
   input  logic             jb,
   input  logic             imem_ready,
   input  logic             mc_done,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic             stall_E,
   output logic             flush_E,
   output logic             mc_go,
   output logic             mc_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MC_WAIT  = 2'b01,
      MC_DRAIN = 2'b10
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] timer, timer_nxt;
   logic       mc_err_q, err_set;
   logic       lu, run_rules;
   logic       s_f, s_d, f_d, s_e, f_e, go;

   assign lu = E_is_load && (E_rd != 5'd0) &&
               ((D_rs1_used && D_rs1 == E_rd) || (D_rs2_used && D_rs2 == E_rd));

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      err_set   = 1'b0;
      run_rules = 1'b0;
      s_f = 1'b0; s_d = 1'b0; f_d = 1'b0;
      s_e = 1'b0; f_e = 1'b0; go  = 1'b0;

      case (state)
         RUN: begin
            if (E_is_mc) begin
               go = 1'b1; s_f = 1'b1; s_d = 1'b1; s_e = 1'b1;
               state_nxt = MC_WAIT;
               timer_nxt = 8'd0;
            end else begin
               run_rules = 1'b1;
            end
         end
         MC_WAIT: begin
            s_f = 1'b1; s_d = 1'b1; s_e = 1'b1;
            timer_nxt = timer + 8'd1;
            if (mc_done) begin
               state_nxt = MC_DRAIN;
            end else if (timer == TO_LAST) begin
               err_set   = 1'b1;
               state_nxt = MC_DRAIN;
            end
         end
         MC_DRAIN: begin
            // E_is_mc is still high here (the finished op sits in E), so no restart check.
            run_rules = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase

      if (run_rules) begin
         if (jb) begin
            f_d = 1'b1; f_e = 1'b1;
         end else if (lu) begin
            s_f = 1'b1; s_d = 1'b1; f_e = 1'b1;
         end else if (!imem_ready) begin
            s_f = 1'b1; f_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         timer    <= 8'd0;
         mc_err_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         mc_err_q <= mc_err_q | err_set;
      end
   end

   assign stall_F = rst & s_f;
   assign stall_D = rst & s_d;
   assign flush_D = rst & f_d;
   assign stall_E = rst & s_e;
   assign flush_E = rst & f_e;
   assign mc_go   = rst & go;
   assign mc_err  = rst & mc_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_F && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if ((flush_D || flush_E) && !(&flush_cnt_q))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed expectations each cycle,
// a monitor pops and compares them on the falling edge.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [4:0] D_rs1, D_rs2, E_rd;
   logic D_rs1_used, D_rs2_used, E_is_load, E_is_mc, jb, imem_ready, mc_done;
   logic stall_F, stall_D, flush_D, stall_E, flush_E, mc_go, mc_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .D_rs1(D_rs1), .D_rs2(D_rs2), .D_rs1_used(D_rs1_used), .D_rs2_used(D_rs2_used),
      .E_rd(E_rd), .E_is_load(E_is_load), .E_is_mc(E_is_mc), .jb(jb),
      .imem_ready(imem_ready), .mc_done(mc_done),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .stall_E(stall_E),
      .flush_E(flush_E), .mc_go(mc_go), .mc_err(mc_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Expected control vector: {stall_F, stall_D, flush_D, stall_E, flush_E, mc_go, mc_err}
   localparam logic [6:0] Z    = 7'b0000000;
   localparam logic [6:0] LU   = 7'b1100100;
   localparam logic [6:0] JB   = 7'b0010100;
   localparam logic [6:0] IM   = 7'b1010000;
   localparam logic [6:0] MCGO = 7'b1101010;
   localparam logic [6:0] MCS  = 7'b1101000;
   localparam logic [6:0] ERR  = 7'b0000001;

   typedef struct {
      logic [6:0]       ctl;
      bit               cnt_chk;
      logic [CNT_W-1:0] s_cnt;
      logic [CNT_W-1:0] f_cnt;
      string            name;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Advance to just after the next rising edge and return inputs to an idle, hazard-free pattern.
   task automatic next();
      @(posedge clk);
      #1;
      D_rs1 = 5'd0; D_rs2 = 5'd0; E_rd = 5'd0;
      D_rs1_used = 1'b0; D_rs2_used = 1'b0;
      E_is_load = 1'b0; E_is_mc = 1'b0; jb = 1'b0;
      imem_ready = 1'b1; mc_done = 1'b0;
   endtask

   task automatic expect_ctl(input logic [6:0] ctl, input string nm);
      exp_t e;
      e.ctl = ctl; e.cnt_chk = 1'b0; e.s_cnt = '0; e.f_cnt = '0; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic expect_cnt(input logic [6:0] ctl, input string nm,
                             input int s_perf, input int f_perf);
      exp_t e;
      e.ctl = ctl; e.cnt_chk = 1'b1; e.name = nm;
      e.s_cnt = PERF ? CNT_W'(s_perf) : '0;
      e.f_cnt = PERF ? CNT_W'(f_perf) : '0;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, 32'({stall_F, stall_D, flush_D, stall_E, flush_E, mc_go, mc_err}), 32'(e.ctl));
         if (e.cnt_chk) begin
            check({e.name, "_stall_cnt"}, stall_cnt, e.s_cnt);
            check({e.name, "_flush_cnt"}, flush_cnt, e.f_cnt);
         end
      end
   end

   initial begin
      rst = 1'b0;
      // Reset held with hazardous inputs: everything must read 0.
      for (int i = 0; i < 2; i++) begin
         next(); jb = 1'b1; E_is_mc = 1'b1; imem_ready = 1'b0;
         expect_cnt(Z, "in_reset", 0, 0);
      end
      next(); rst = 1'b1; expect_ctl(Z, "reset_release");
      for (int i = 0; i < 9; i++) begin
         next(); expect_ctl(Z, "idle");
      end
      next(); expect_cnt(Z, "idle_cnt", 0, 0);

      // Three fetch waits then one redirect.
      for (int i = 0; i < 3; i++) begin
         next(); imem_ready = 1'b0; expect_ctl(IM, "imem_wait");
      end
      next(); jb = 1'b1; expect_ctl(JB, "jb_plain");
      next(); expect_cnt(Z, "perf_cnt", 3, 4);

      // Load-use via rs2, then bubble cycle.
      next(); E_is_load = 1'b1; E_rd = 5'd5; D_rs2 = 5'd5; D_rs2_used = 1'b1;
      expect_ctl(LU, "lu_rs2");
      next(); expect_ctl(Z, "lu_after");
      // Load-use with redirect: redirect wins.
      next(); E_is_load = 1'b1; E_rd = 5'd5; D_rs2 = 5'd5; D_rs2_used = 1'b1; jb = 1'b1;
      expect_ctl(JB, "lu_jb");
      // x0 destination never hazards.
      next(); E_is_load = 1'b1; E_rd = 5'd0; D_rs1 = 5'd0; D_rs1_used = 1'b1;
      expect_ctl(Z, "lu_x0");
      // Matching register that is not read.
      next(); E_is_load = 1'b1; E_rd = 5'd9; D_rs2 = 5'd9; D_rs2_used = 1'b0;
      expect_ctl(Z, "lu_unused");
      // Non-load producer never hazards.
      next(); E_rd = 5'd9; D_rs1 = 5'd9; D_rs1_used = 1'b1;
      expect_ctl(Z, "no_load");
      // rs1 match while fetch not ready: load-use outranks fetch wait.
      next(); E_is_load = 1'b1; E_rd = 5'd31; D_rs1 = 5'd31; D_rs1_used = 1'b1; imem_ready = 1'b0;
      expect_ctl(LU, "lu_rs1_imem");

      // Multi-cycle op, done 4 cycles after go.
      next(); E_is_mc = 1'b1; expect_ctl(MCGO, "mc_go");
      for (int i = 0; i < 3; i++) begin
         next(); E_is_mc = 1'b1; jb = 1'b1; imem_ready = 1'b0;
         E_is_load = 1'b1; E_rd = 5'd3; D_rs1 = 5'd3; D_rs1_used = 1'b1;
         expect_ctl(MCS, "mc_wait");
      end
      next(); E_is_mc = 1'b1; mc_done = 1'b1; expect_ctl(MCS, "mc_done");
      next(); E_is_mc = 1'b1; jb = 1'b1; expect_ctl(JB, "mc_drain_jb");
      next(); mc_done = 1'b1; expect_ctl(Z, "stray_done");
      next(); expect_ctl(Z, "after_mc");

      // Timeout: 8 stall cycles after go, then drain with error set.
      next(); E_is_mc = 1'b1; expect_ctl(MCGO, "to_go");
      for (int i = 0; i < 8; i++) begin
         next(); E_is_mc = 1'b1; expect_ctl(MCS, "to_wait");
      end
      next(); E_is_mc = 1'b1; imem_ready = 1'b0; expect_ctl(IM | ERR, "to_drain");
      next(); expect_ctl(ERR, "err_sticky");
      next(); mc_done = 1'b1; expect_ctl(ERR, "late_done");
      next(); rst = 1'b0; expect_cnt(Z, "err_reset", 0, 0);
      next(); rst = 1'b1; expect_ctl(Z, "err_cleared");

      // Reset mid-wait returns to RUN without reissuing go.
      next(); E_is_mc = 1'b1; expect_ctl(MCGO, "rw_go");
      for (int i = 0; i < 2; i++) begin
         next(); E_is_mc = 1'b1; expect_ctl(MCS, "rw_wait");
      end
      next(); rst = 1'b0; E_is_mc = 1'b1; expect_ctl(Z, "rw_reset");
      next(); rst = 1'b1; expect_ctl(Z, "rw_run");
      next(); expect_ctl(Z, "rw_idle");
      next(); E_is_mc = 1'b1; expect_ctl(MCGO, "rw_go2");
      next(); E_is_mc = 1'b1; mc_done = 1'b1; expect_ctl(MCS, "rw_done");
      next(); E_is_mc = 1'b1; expect_ctl(Z, "rw_drain");
      next(); expect_ctl(Z, "rw_end");

      begin
         int budget = 20;
         while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
